// File: rtl/fmap_pkg.sv
// Shared state encoding and default widths for the feature-map line transmitter.
package fmap_pkg;

  localparam int FMAP_AW = 10;
  localparam int FMAP_DW = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } fmap_state_e;

endpackage

// File: rtl/fmap_tx_outreg.sv
// Single-entry output register for fmap_line_tx: holds the word and its frame
// position flags, and reloads whenever it is empty or its beat is taken.
module fmap_tx_outreg
  import fmap_pkg::*;
#(
  parameter int DW = FMAP_DW
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          first_in,
  input  logic          line_in,
  input  logic          frame_in,
  input  logic          wready,
  output logic [DW-1:0] data,
  output logic          data_vld,
  output logic          first,
  output logic          last_in_line,
  output logic          last_in_frame,
  output logic          ld
);

  assign ld = !data_vld || wready;

  // When ld is high without a new word, the register empties so no beat repeats.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      data          <= '0;
      data_vld      <= 1'b0;
      first         <= 1'b0;
      last_in_line  <= 1'b0;
      last_in_frame <= 1'b0;
    end else if (ld) begin
      if (load) begin
        data          <= din;
        data_vld      <= 1'b1;
        first         <= first_in;
        last_in_line  <= line_in;
        last_in_frame <= frame_in;
      end else begin
        data_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fmap_line_tx.sv
// Feature-map line transmitter: streams one PIC_SIZE x PIC_SIZE picture under WREADY
// backpressure. Define FMAP_TX_LINE_GAP_EN to insert LINE_GAP idle cycles between lines.
module fmap_line_tx
  import fmap_pkg::*;
#(
  parameter int AW = FMAP_AW,
  parameter int DW = FMAP_DW,
  parameter int LINE_GAP = 1
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  input  logic          START,
  input  logic [7:0]    PIC_SIZE,
  input  logic [AW-1:0] WRADDR_BASE,
  input  logic [DW-1:0] SRC_DATA,
  input  logic          SRC_VLD,
  output logic          SRC_RDY,
  output logic [DW-1:0] DATA,
  output logic          DATA_VLD,
  input  logic          WREADY,
  output logic          DATA_SOP,
  output logic          DATA_HSYNC,
  output logic          DATA_EOP,
  output logic [AW-1:0] WRADDR_START,
  output logic          BUSY
);

  fmap_state_e state, state_nxt;
  logic [7:0]  pic_size, col_cnt, row_cnt;
  logic        ld, src_hs, col_last, row_last, beat_xfer, frame_done, start_ok, eop_q;
  logic        first_q, line_q, frame_q;

  // The EOP cycle still counts as busy, so a START there is ignored.
  assign start_ok   = (state == IDLE) && !eop_q && START && (PIC_SIZE >= 8'd2);
  assign SRC_RDY    = (state == SEND) && ld;
  assign src_hs     = SRC_VLD && SRC_RDY;
  assign col_last   = (col_cnt == pic_size - 8'd1);
  assign row_last   = (row_cnt == pic_size - 8'd1);
  assign beat_xfer  = DATA_VLD && WREADY;
  assign frame_done = (state == DRAIN) && beat_xfer && frame_q;

  assign DATA_SOP   = first_q && beat_xfer;
  assign DATA_HSYNC = line_q && beat_xfer;
  assign DATA_EOP   = eop_q;
  assign BUSY       = (state != IDLE) || eop_q;

`ifdef FMAP_TX_LINE_GAP_EN
  logic [7:0] gap_cnt;
  logic       gap_done;

  // Counting begins on the cycle the tagged last beat leaves (ld high in GAP).
  assign gap_done = (state == GAP) && ld && (gap_cnt == 8'(LINE_GAP - 1));

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST)           gap_cnt <= '0;
    else if (state != GAP)  gap_cnt <= '0;
    else if (ld)            gap_cnt <= gap_cnt + 8'd1;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = SEND;
      SEND:  if (src_hs && col_last) begin
               if (row_last) state_nxt = DRAIN;
`ifdef FMAP_TX_LINE_GAP_EN
               else          state_nxt = GAP;
`endif
             end
`ifdef FMAP_TX_LINE_GAP_EN
      GAP:   if (gap_done) state_nxt = SEND;
`endif
      DRAIN: if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state        <= IDLE;
      pic_size     <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      WRADDR_START <= '0;
      eop_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      eop_q <= frame_done;
      if (start_ok) begin
        pic_size     <= PIC_SIZE;
        WRADDR_START <= WRADDR_BASE;
        col_cnt      <= '0;
        row_cnt      <= '0;
      end else if (src_hs) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? 8'd0 : row_cnt + 8'd1;
        end else begin
          col_cnt <= col_cnt + 8'd1;
        end
      end
    end
  end

  fmap_tx_outreg #(.DW(DW)) u_outreg (
    .SYS_CLK       (SYS_CLK),
    .SYS_RST       (SYS_RST),
    .load          (src_hs),
    .din           (SRC_DATA),
    .first_in      ((col_cnt == 8'd0) && (row_cnt == 8'd0)),
    .line_in       (col_last),
    .frame_in      (col_last && row_last),
    .wready        (WREADY),
    .data          (DATA),
    .data_vld      (DATA_VLD),
    .first         (first_q),
    .last_in_line  (line_q),
    .last_in_frame (frame_q),
    .ld            (ld)
  );

endmodule
